// File: rtl/conv_layer2_vmem_update.sv
// conv_layer2_vmem_update: layer-2 membrane update pipeline with clear sweep and AER spike FIFO.
// Define CONV2_LEAK_EN to compile in the per-timestep leak sweep.
module conv_layer2_vmem_update #(
    parameter int VMEM_W = 16,
    parameter int W_W = 8,
    parameter int ADDR_W = 10,
    parameter logic signed [VMEM_W-1:0] THRESH = 16'sd256,
    parameter logic signed [VMEM_W-1:0] V_RESET = '0,
    parameter logic signed [VMEM_W-1:0] LEAK = 16'sd4,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                     work_clk,
    input  logic                     rst_n,
    input  logic                     operating_flag,
    input  logic [ADDR_W-1:0]        A_Vmem,
    input  logic [4:0]               current_M,
    input  logic [4:0]               current_N,
    input  logic signed [W_W-1:0]    weight_data,
    input  logic                     timestep_end,
    output logic [9:0]               spike_aer,
    output logic                     spike_valid,
    input  logic                     spike_ready,
    output logic                     busy,
    output logic                     drop_flag
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = ADDR_W + 1;
    localparam logic [CW-1:0] LAST = CW'((1 << ADDR_W) - 1);
`ifdef CONV2_LEAK_EN
    localparam logic [CW-1:0] LAST2 = CW'((1 << ADDR_W) + 1);
    typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_LEAK} state_t;
    logic pend_q, pend_d;
`else
    typedef enum logic {S_CLEAR, S_IDLE} state_t;
    logic unused_ok;
    assign unused_ok = timestep_end;
`endif
    state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic b_valid_q, b_valid_d, b_leak_q, b_leak_d, c_valid_q, c_valid_d, c_fire_q, c_fire_d;
    logic [ADDR_W-1:0] b_addr_q, b_addr_d, c_addr_q, c_addr_d, wa;
    logic [9:0] b_mn_q, b_mn_d, c_mn_q, c_mn_d;
    logic signed [VMEM_W-1:0] c_data_q, c_data_d, rdata_q, src, sat, leaked, wd;
    logic signed [VMEM_W:0] sum;
    logic [PW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic drop_q, drop_d;
    logic accept, leak_issue, we, empty, full, push, push_ok, pop, fire;
    logic signed [VMEM_W-1:0] vmem_q [2**ADDR_W];
    logic [9:0] fifo_q [FIFO_DEPTH];

    assign busy = state_q != S_IDLE;
    assign drop_flag = drop_q;
    assign spike_valid = !empty;
    assign spike_aer = empty ? '0 : fifo_q[rd_ptr_q[PW-1:0]];

    always_comb begin
        accept = operating_flag && state_q == S_IDLE;
`ifdef CONV2_LEAK_EN
        leak_issue = state_q == S_LEAK && cnt_q <= LAST;
`else
        leak_issue = 1'b0;
`endif
        b_valid_d = accept || leak_issue;
        b_leak_d = leak_issue;
        b_addr_d = leak_issue ? cnt_q[ADDR_W-1:0] : A_Vmem;
        b_mn_d = {current_M, current_N};
        // Stage C write data overrides the RAM read still in flight for the same neuron.
        src = (c_valid_q && c_addr_q == b_addr_q) ? c_data_q : rdata_q;
        sum = {src[VMEM_W-1], src} + {{(VMEM_W+1-W_W){weight_data[W_W-1]}}, weight_data};
        sat = (sum[VMEM_W] != sum[VMEM_W-1]) ?
              (sum[VMEM_W] ? {1'b1, {(VMEM_W-1){1'b0}}} : {1'b0, {(VMEM_W-1){1'b1}}}) :
              sum[VMEM_W-1:0];
        leaked = src > LEAK ? src - LEAK : src < -LEAK ? src + LEAK : '0;
        fire = sat >= THRESH;
        c_valid_d = b_valid_q;
        c_addr_d = b_addr_q;
        c_mn_d = b_mn_q;
        c_fire_d = b_valid_q && !b_leak_q && fire;
        c_data_d = b_leak_q ? leaked : (fire ? V_RESET : sat);
        we = rst_n && (state_q == S_CLEAR || c_valid_q);
        wa = state_q == S_CLEAR ? cnt_q[ADDR_W-1:0] : c_addr_q;
        wd = state_q == S_CLEAR ? '0 : c_data_q;
        empty = wr_ptr_q == rd_ptr_q;
        full = wr_ptr_q == {~rd_ptr_q[PW], rd_ptr_q[PW-1:0]};
        pop = spike_ready && !empty;
        push = c_valid_q && c_fire_q;
        push_ok = push && (!full || pop);
        wr_ptr_d = push_ok ? wr_ptr_q + (PW+1)'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + (PW+1)'(1) : rd_ptr_q;
        drop_d = drop_q || (operating_flag && busy) || (push && !push_ok);
        state_d = state_q;
        cnt_d = cnt_q;
`ifdef CONV2_LEAK_EN
        pend_d = pend_q || timestep_end;
`endif
        if (state_q == S_CLEAR) begin
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == LAST) begin
                state_d = S_IDLE;
                cnt_d = '0;
            end
        end
`ifdef CONV2_LEAK_EN
        else if (state_q == S_IDLE) begin
            if (pend_d && !b_valid_q && !c_valid_q) begin
                state_d = S_LEAK;
                pend_d = 1'b0;
            end
        end else begin
            // Two extra cycles let the last leak write drain out of stage C.
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == LAST2) begin
                state_d = S_IDLE;
                cnt_d = '0;
            end
        end
`endif
    end

    always_ff @(posedge work_clk) begin
        if (!rst_n) begin
            state_q <= S_CLEAR;
            cnt_q <= '0;
`ifdef CONV2_LEAK_EN
            pend_q <= 1'b0;
`endif
            b_valid_q <= 1'b0;
            b_leak_q <= 1'b0;
            b_addr_q <= '0;
            b_mn_q <= '0;
            c_valid_q <= 1'b0;
            c_fire_q <= 1'b0;
            c_addr_q <= '0;
            c_mn_q <= '0;
            c_data_q <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            drop_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
`ifdef CONV2_LEAK_EN
            pend_q <= pend_d;
`endif
            b_valid_q <= b_valid_d;
            b_leak_q <= b_leak_d;
            b_addr_q <= b_addr_d;
            b_mn_q <= b_mn_d;
            c_valid_q <= c_valid_d;
            c_fire_q <= c_fire_d;
            c_addr_q <= c_addr_d;
            c_mn_q <= c_mn_d;
            c_data_q <= c_data_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            drop_q <= drop_d;
        end
    end

    always_ff @(posedge work_clk) begin
        if (we)
            vmem_q[wa] <= wd;
        rdata_q <= (we && wa == b_addr_d) ? wd : vmem_q[b_addr_d];
        if (push_ok)
            fifo_q[wr_ptr_q[PW-1:0]] <= c_mn_q;
    end
endmodule

// File: doc/conv_layer2_vmem_update.md
# conv_layer2_vmem_update

Membrane-potential update stage for convolution layer 2, sitting directly downstream of the layer-2 address generator. For every cycle in which the generator asserts `operating_flag`, it reads the addressed membrane potential, adds the signed synaptic weight returned by the weight ROM, applies saturation and threshold, writes the result back, and queues a spike event when the neuron fires. It also performs the power-up clear sweep, an optional per-timestep leak sweep, and buffers output spikes in an AER FIFO feeding layer-2 pooling/output logic.

## Interface
- `VMEM_W`, 16: signed membrane-potential width.
- `W_W`, 8: signed weight width; weights are sign-extended to `VMEM_W`.
- `ADDR_W`, 10: membrane-RAM address width; depth is 2^`ADDR_W`.
- `THRESH`, 16'sd256: firing threshold; a neuron fires when the updated value is >= `THRESH`.
- `V_RESET`, 0: value written back on fire.
- `LEAK`, 16'sd4: leak magnitude per timestep (used only with leak compiled in).
- `FIFO_DEPTH`, 16: spike FIFO depth, power of two.
- `work_clk` in 1: the block's single clock, rising edge.
- `rst_n` in 1: synchronous, active-low reset, sampled on `work_clk`.
- `operating_flag` in 1: update request; qualifies `A_Vmem`, `current_M`, `current_N`.
- `A_Vmem` in `ADDR_W`: membrane address to update.
- `current_M` in 5: row of the addressed neuron.
- `current_N` in 5: column of the addressed neuron.
- `weight_data` in `W_W`: weight-ROM read data, valid one cycle after the matching `operating_flag` cycle.
- `timestep_end` in 1: single-cycle pulse marking the end of an input timestep.
- `spike_aer` out 10: `{M[4:0], N[4:0]}` of the firing neuron.
- `spike_valid` out 1: FIFO non-empty.
- `spike_ready` in 1: consumer accepts; pop on `spike_valid & spike_ready`.
- `busy` out 1: CLEAR or LEAK sweep in progress.
- `drop_flag` out 1: sticky error; cleared only by reset.

## Operation
- FSM states: CLEAR, IDLE, LEAK. Reset enters CLEAR. CLEAR writes 0 to addresses 0..2^`ADDR_W`-1, one per cycle, then enters IDLE. IDLE handles update requests. On `timestep_end` in IDLE, the FSM enters LEAK, sweeps all addresses, then returns to IDLE.
- Update pipeline, with the request in cycle t:
  - Stage A (t): the RAM read is issued at `A_Vmem`, and the address and coordinates are registered.
  - Stage B (t+1): `sum = rdata + sext(weight_data)`, computed at `VMEM_W+1` bits and saturated to the signed `VMEM_W` range. If `sum >= THRESH`, the write data is `V_RESET` and fire = 1; otherwise the write data is `sum`.
  - Stage C (t+2): RAM write occurs; on fire, `{M,N}` is pushed into the FIFO.
- Hazard forwarding: when the stage-B read address equals the stage-C write address, stage B uses the stage-C write data instead of RAM data. Back-to-back requests to the same address therefore accumulate correctly.
- `operating_flag` while `busy` = 1: the request is ignored and `drop_flag` is set.
- `timestep_end` during CLEAR or LEAK, or while the pipeline holds a valid stage: it is held pending and LEAK starts once the FSM is in IDLE with an empty pipeline.
- Requests arriving while a leak is pending are still accepted until LEAK begins.
- FIFO full with a fire in stage C: the membrane write still occurs, the event is discarded, and `drop_flag` is set. A push and a pop in the same cycle are both honoured when the FIFO is full.

## Timing
- Reset values: `spike_aer` = 0, `spike_valid` = 0, `busy` = 1 (CLEAR is entered), `drop_flag` = 0. FIFO pointers and all pipeline valids are cleared.
- The CLEAR sweep takes 2^`ADDR_W` cycles. `busy` falls the cycle after the last address is written.
- Request-to-spike latency: a request at cycle t gives `spike_valid` = 1 at t+3 when the FIFO was empty.
- Throughput is one update per cycle with no back-pressure toward the generator.
- LEAK takes 2^`ADDR_W` cycles plus 2 cycles of pipeline drain, and never fires or pushes events.
- Reset asserted mid-pipeline or mid-sweep: in-flight writes are abandoned, queued spikes are lost, and CLEAR restarts from address 0.

## Configuration
- `CONV2_LEAK_EN` defined: LEAK state and sweep present. Each neuron moves toward 0 by `LEAK` and clamps at 0 (v > LEAK gives v−LEAK; v < −LEAK gives v+LEAK; otherwise 0).
- `CONV2_LEAK_EN` undefined: no LEAK state. `timestep_end` is ignored, and `busy` is high only during CLEAR.

## Test plan
- Reset, wait for the CLEAR sweep (1024 cycles). Then `busy` = 0, and reading any address via an update with weight 0 gives no spike and the membrane stays 0.
- Weight 100 applied three times to address 37, (M,N) = (1,5), spaced 5 cycles apart. The third update fires (300 ≥ 256): `spike_aer` = 10'b00001_00101 appears 3 cycles after the third request, and the membrane returns to 0.
- Same address on back-to-back cycles with weights 200 and 100 → fire on the second update (forwarding exercised), and exactly one spike.
- `spike_ready` = 0 with 17 firing updates → 16 events queued, `drop_flag` = 1. Then `spike_ready` = 1 drains 16 events in order.
- With `CONV2_LEAK_EN` defined: membrane set to 10 at address 5 and −3 at address 6, then `timestep_end` is pulsed. After the sweep, address 5 holds 6, address 6 holds 0, and an `operating_flag` during the sweep sets `drop_flag`.
- Weight +127 applied repeatedly with `THRESH` = 16'sh7FFF → the value saturates at 32767 without wrapping, then fires.
